// File: rtl/pe_time_proc_if.sv
// pe_time_proc_if: state-vector bus into and out of the time-update PE.
//   x_curr / x_curr_valid : sigma point in (px, vx, py, vy, w), Q16.16 each
//   x_next / x_next_valid : propagated sigma point out, same layout
// master = producer/consumer side (testbench, sigma-point generator),
// slave  = the processing element.
interface pe_time_proc_if;
  logic [159:0] x_curr;
  logic         x_curr_valid;
  logic [159:0] x_next;
  logic         x_next_valid;

  modport master (output x_curr, x_curr_valid, input  x_next, x_next_valid);
  modport slave  (input  x_curr, x_curr_valid, output x_next, x_next_valid);
endinterface

// File: rtl/pe_time_proc_core.sv
// pe_time_proc_core: coordinated-turn time-update for one sigma point.
// Second-order small-angle model over period T, signed Q16.16 throughout,
// four-stage pipeline, one sample per enabled cycle, no backpressure.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset, clears all pipeline state
//   en_clk : clock enable, freezes data and valids when low
//   bus    : pe_time_proc_if.slave (x_curr/x_curr_valid in, x_next/x_next_valid out)
module pe_time_proc_core #(
  parameter logic signed [31:0] T = 32'sh0001_0000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_clk,
  pe_time_proc_if.slave    bus
);
  localparam int STAGES = 4;

  typedef logic signed [31:0] q_t;
  localparam q_t ONE = 32'sh0001_0000;

  typedef struct packed { q_t px, vx, py, vy, w; } st_t;
  typedef struct packed { q_t px, vx, py, vy, w, a; } s1_t;
  typedef struct packed { q_t px, vx, py, vy, w, a, h, k, tvx, tvy; } s2_t;
  typedef struct packed { q_t px, py, w, tvx, tvy, kvx, kvy, cvx, cvy, avx, avy; } s3_t;

  // Full 64-bit product, keep [47:16]: arithmetic shift then truncate.
  function automatic q_t mul(q_t x, q_t y);
    logic signed [63:0] p;
    p = 64'(x) * 64'(y);
    return q_t'(p >>> 16);
  endfunction

  st_t  in_s, x_next_q;
  s1_t  s1;
  s2_t  s2;
  s3_t  s3;
  q_t   s2_c;
  logic [STAGES:1] vld_pipe;

  assign in_s = st_t'(bus.x_curr);
  // cos(wT) ~ 1 - (wT)^2/2; the subtraction is cheap so it lives in front of S3's multipliers
  assign s2_c = ONE - s2.h;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1       <= '0;
      s2       <= '0;
      s3       <= '0;
      x_next_q <= '0;
      vld_pipe <= '0;
    end else if (en_clk) begin
      // S1: capture, a = wT
      s1.px <= in_s.px;
      s1.vx <= in_s.vx;
      s1.py <= in_s.py;
      s1.vy <= in_s.vy;
      s1.w  <= in_s.w;
      s1.a  <= mul(in_s.w, T);
      // S2: h = a^2/2, k = aT/2 ~ (1-cos wT)/w, and the T-scaled velocities
      s2.px  <= s1.px;
      s2.vx  <= s1.vx;
      s2.py  <= s1.py;
      s2.vy  <= s1.vy;
      s2.w   <= s1.w;
      s2.a   <= s1.a;
      s2.h   <= mul(s1.a, s1.a) >>> 1;
      s2.k   <= mul(s1.a, T) >>> 1;
      s2.tvx <= mul(T, s1.vx);
      s2.tvy <= mul(T, s1.vy);
      // S3: remaining products, each truncated on its own
      s3.px  <= s2.px;
      s3.py  <= s2.py;
      s3.w   <= s2.w;
      s3.tvx <= s2.tvx;
      s3.tvy <= s2.tvy;
      s3.kvx <= mul(s2.k, s2.vx);
      s3.kvy <= mul(s2.k, s2.vy);
      s3.cvx <= mul(s2_c, s2.vx);
      s3.cvy <= mul(s2_c, s2.vy);
      s3.avx <= mul(s2.a, s2.vx);
      s3.avy <= mul(s2.a, s2.vy);
      // S4: wrap-around sums
      x_next_q.px <= s3.px + s3.tvx - s3.kvy;
      x_next_q.vx <= s3.cvx - s3.avy;
      x_next_q.py <= s3.py + s3.kvx + s3.tvy;
      x_next_q.vy <= s3.avx + s3.cvy;
      x_next_q.w  <= s3.w;
      vld_pipe    <= {vld_pipe[STAGES-1:1], bus.x_curr_valid};
    end
  end

  assign bus.x_next       = x_next_q;
  assign bus.x_next_valid = vld_pipe[STAGES];
endmodule

// File: tb/tb_pe_time_proc_core.sv
module tb_pe_time_proc_core;
  localparam logic [31:0] T1 = 32'h0001_0000;
  localparam logic [31:0] T2 = 32'h0000_1999;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en_clk = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  pe_time_proc_if bus ();
  pe_time_proc_if bus2 ();
  assign bus2.x_curr       = bus.x_curr;
  assign bus2.x_curr_valid = bus.x_curr_valid;

  pe_time_proc_core #(.T(T1)) dut  (.clk(clk), .rst_n(rst_n), .en_clk(en_clk), .bus(bus.slave));
  pe_time_proc_core #(.T(T2)) dut2 (.clk(clk), .rst_n(rst_n), .en_clk(en_clk), .bus(bus2.slave));

  always #5 clk = ~clk;

  // Reference: real-valued products scaled by 2^16 and floored, 32-bit wrap.
  function automatic logic [31:0] qm(logic [31:0] a, logic [31:0] b);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    p = p >>> 16;
    return p[31:0];
  endfunction

  function automatic logic [159:0] model(logic [159:0] x, logic [31:0] t);
    logic [31:0] px, vx, py, vy, w, a, h, c, k;
    {px, vx, py, vy, w} = x;
    a = qm(w, t);
    h = $signed(qm(a, a)) >>> 1;
    c = 32'h0001_0000 - h;
    k = $signed(qm(a, t)) >>> 1;
    return {px + qm(t, vx) - qm(k, vy), qm(c, vx) - qm(a, vy),
            py + qm(k, vx) + qm(t, vy), qm(a, vx) + qm(c, vy), w};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [159:0] x, input logic v, input logic e);
    bus.x_curr       = x;
    bus.x_curr_valid = v;
    en_clk           = e;
  endtask

  function automatic logic [159:0] rnd_state();
    return {$urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic test_reset;
    drive('0, 1'b0, 1'b1);
    rst_n = 1'b0;
    #12;
    n_chk++; if (bus.x_next !== '0 || bus.x_next_valid !== 1'b0) begin n_fail++;
      $display("FAIL reset_state: x_next=%h valid=%b, want 0/0", bus.x_next, bus.x_next_valid); end
    n_chk++; if (bus2.x_next !== '0 || bus2.x_next_valid !== 1'b0) begin n_fail++;
      $display("FAIL reset_state_t2: x_next=%h valid=%b, want 0/0", bus2.x_next, bus2.x_next_valid); end
    tick;
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_straight;
    logic [159:0] s, e;
    s = {32'h03e8_0000, 32'h012c_0000, 32'h03e8_0000, 32'h0, 32'h0};
    e = {32'h0514_0000, 32'h012c_0000, 32'h03e8_0000, 32'h0, 32'h0};
    drive(s, 1'b1, 1'b1);
    tick;
    drive('0, 1'b0, 1'b1);
    for (int i = 1; i <= 2; i++) begin
      tick;
      n_chk++; if (bus.x_next_valid !== 1'b0) begin n_fail++;
        $display("FAIL straight_early_valid: edge+%0d valid=%b want 0", i, bus.x_next_valid); end
    end
    tick;
    n_chk++; if (bus.x_next_valid !== 1'b1 || bus.x_next !== e) begin n_fail++;
      $display("FAIL straight_result: valid=%b x_next=%h want 1 %h", bus.x_next_valid, bus.x_next, e); end
    n_chk++; if (bus2.x_next !== model(s, T2)) begin n_fail++;
      $display("FAIL straight_t2: x_next=%h want %h", bus2.x_next, model(s, T2)); end
    tick;
    n_chk++; if (bus.x_next_valid !== 1'b0) begin n_fail++;
      $display("FAIL straight_valid_once: valid=%b want 0", bus.x_next_valid); end
  endtask

  task automatic test_stream;
    logic [159:0] s [4];
    logic [159:0] e [4];
    s[0] = {32'h0, 32'h0001_0000, 32'h0, 32'h0, 32'h0001_0000};
    e[0] = {32'h0001_0000, 32'h0000_8000, 32'h0000_8000, 32'h0001_0000, 32'h0001_0000};
    s[1] = {32'h03e8_0000, 32'h012c_0000, 32'h03e8_0000, 32'h0, 32'h0};
    e[1] = {32'h0514_0000, 32'h012c_0000, 32'h03e8_0000, 32'h0, 32'h0};
    s[2] = {32'h0, 32'h0, 32'h0, 32'h0001_0000, 32'h0};
    e[2] = {32'h0, 32'h0, 32'h0001_0000, 32'h0001_0000, 32'h0};
    s[3] = {$urandom, $urandom, $urandom, $urandom, 32'hffff_f1fe};
    e[3] = model(s[3], T1);
    for (int c = 0; c < 8; c++) begin
      if (c < 4) drive(s[c], 1'b1, 1'b1);
      else       drive('0, 1'b0, 1'b1);
      tick;
      if (c >= 3 && c <= 6) begin
        n_chk++; if (bus.x_next_valid !== 1'b1 || bus.x_next !== e[c-3]) begin n_fail++;
          $display("FAIL stream_result[%0d]: valid=%b x_next=%h want 1 %h", c-3, bus.x_next_valid, bus.x_next, e[c-3]); end
        n_chk++; if (bus2.x_next_valid !== 1'b1 || bus2.x_next !== model(s[c-3], T2)) begin n_fail++;
          $display("FAIL stream_t2[%0d]: x_next=%h want %h", c-3, bus2.x_next, model(s[c-3], T2)); end
      end else begin
        n_chk++; if (bus.x_next_valid !== 1'b0) begin n_fail++;
          $display("FAIL stream_idle_valid: edge %0d valid=%b want 0", c, bus.x_next_valid); end
      end
      if (c == 6) begin
        n_chk++; if (bus.x_next[31:0] !== 32'hffff_f1fe) begin n_fail++;
          $display("FAIL stream_neg_omega: w=%h want ffff_f1fe", bus.x_next[31:0]); end
      end
    end
  endtask

  task automatic test_stall;
    logic [159:0] a, b;
    a = rnd_state();
    b = rnd_state();
    drive(a, 1'b1, 1'b1); tick;
    drive(b, 1'b1, 1'b1); tick;
    drive('0, 1'b0, 1'b1); tick; tick;
    n_chk++; if (bus.x_next_valid !== 1'b1 || bus.x_next !== model(a, T1)) begin n_fail++;
      $display("FAIL stall_first: valid=%b x_next=%h want 1 %h", bus.x_next_valid, bus.x_next, model(a, T1)); end
    for (int i = 0; i < 5; i++) begin
      drive(rnd_state(), 1'b1, 1'b0);
      tick;
      n_chk++; if (bus.x_next_valid !== 1'b1 || bus.x_next !== model(a, T1)) begin n_fail++;
        $display("FAIL stall_frozen[%0d]: valid=%b x_next=%h want 1 %h", i, bus.x_next_valid, bus.x_next, model(a, T1)); end
      n_chk++; if (bus2.x_next !== model(a, T2)) begin n_fail++;
        $display("FAIL stall_frozen_t2[%0d]: x_next=%h want %h", i, bus2.x_next, model(a, T2)); end
    end
    drive('0, 1'b0, 1'b1); tick;
    n_chk++; if (bus.x_next_valid !== 1'b1 || bus.x_next !== model(b, T1)) begin n_fail++;
      $display("FAIL stall_resume: valid=%b x_next=%h want 1 %h", bus.x_next_valid, bus.x_next, model(b, T1)); end
    for (int i = 0; i < 4; i++) begin
      tick;
      n_chk++; if (bus.x_next_valid !== 1'b0) begin n_fail++;
        $display("FAIL stall_no_capture[%0d]: valid=%b want 0", i, bus.x_next_valid); end
    end
  endtask

  task automatic test_reset_mid;
    logic [159:0] d;
    for (int i = 0; i < 3; i++) begin drive(rnd_state(), 1'b1, 1'b1); tick; end
    drive('0, 1'b0, 1'b1); tick;
    n_chk++; if (bus.x_next_valid !== 1'b1) begin n_fail++;
      $display("FAIL rstmid_pre_valid: valid=%b want 1", bus.x_next_valid); end
    #2 rst_n = 1'b0;
    #1;
    n_chk++; if (bus.x_next !== '0 || bus.x_next_valid !== 1'b0) begin n_fail++;
      $display("FAIL rstmid_async: x_next=%h valid=%b want 0/0", bus.x_next, bus.x_next_valid); end
    tick;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick;
      n_chk++; if (bus.x_next_valid !== 1'b0 || bus2.x_next_valid !== 1'b0) begin n_fail++;
        $display("FAIL rstmid_stale[%0d]: valid=%b/%b want 0", i, bus.x_next_valid, bus2.x_next_valid); end
    end
    d = rnd_state();
    drive(d, 1'b1, 1'b1); tick;
    drive('0, 1'b0, 1'b1); tick; tick; tick;
    n_chk++; if (bus.x_next_valid !== 1'b1 || bus.x_next !== model(d, T1)) begin n_fail++;
      $display("FAIL rstmid_first: valid=%b x_next=%h want 1 %h", bus.x_next_valid, bus.x_next, model(d, T1)); end
    tick;
  endtask

  task automatic test_wrap;
    logic [159:0] s, e;
    s = {32'h7fff_0000, 32'h0001_0000, 32'h0, 32'h0, 32'h0};
    e = {32'h8000_0000, 32'h0001_0000, 32'h0, 32'h0, 32'h0};
    drive(s, 1'b1, 1'b1); tick;
    drive('0, 1'b0, 1'b1); tick; tick; tick;
    n_chk++; if (bus.x_next_valid !== 1'b1 || bus.x_next !== e) begin n_fail++;
      $display("FAIL wrap: valid=%b x_next=%h want 1 %h", bus.x_next_valid, bus.x_next, e); end
    tick;
  endtask

  typedef struct { logic [159:0] e1; logic [159:0] e2; int cap; } exp_t;

  task automatic test_random;
    exp_t q[$];
    exp_t x;
    int   en_cnt = 0;
    logic v, e;
    logic [159:0] s;
    for (int c = 0; c < 400; c++) begin
      v = (c < 390) ? 1'($urandom_range(0, 1)) : 1'b0;
      e = (c < 390) ? ($urandom_range(0, 4) != 0) : 1'b1;
      s = rnd_state();
      if ($urandom_range(0, 1) == 1) s[31:0] = $urandom_range(0, 32'h0006_0000) - 32'h0003_0000;
      drive(s, v, e);
      tick;
      if (e) begin
        en_cnt++;
        if (v) q.push_back('{model(s, T1), model(s, T2), en_cnt});
        if (bus.x_next_valid === 1'b1) begin
          n_chk++; if (q.size() == 0) begin n_fail++;
            $display("FAIL rand_unexpected: valid result with empty scoreboard at cycle %0d", c); end
          else begin
            x = q.pop_front();
            n_chk++; if (bus.x_next !== x.e1 || bus2.x_next !== x.e2 || en_cnt - x.cap != 3) begin n_fail++;
              $display("FAIL rand_result: x_next=%h/%h want %h/%h lat=%0d want 3", bus.x_next, bus2.x_next, x.e1, x.e2, en_cnt - x.cap); end
          end
        end
      end
    end
    n_chk++; if (q.size() != 0) begin n_fail++;
      $display("FAIL rand_drain: %0d results missing, want 0", q.size()); end
  endtask

  initial begin
    drive('0, 1'b0, 1'b0);
    test_reset;
    test_straight;
    test_stream;
    test_stall;
    test_reset_mid;
    test_wrap;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
